// File: rtl/sgd_mem_arbiter.sv
// Single-port arbiter for the shared sample RAM: loader writes first, SGD/host reads share
// round-robin, and SGD reads are held off until their row is loaded (hwm).
// Optional grant/stall counters are built when ARB_STATS_EN is defined.
module sgd_mem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 192,
  parameter int RD_LAT = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ld_start,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  input  logic              sgd_req,
  input  logic [ADDR_W-1:0] sgd_addr,
  output logic              sgd_gnt,
  output logic              sgd_rvalid,
  output logic [DATA_W-1:0] sgd_rdata,
  input  logic              hst_req,
  input  logic [ADDR_W-1:0] hst_addr,
  output logic              hst_gnt,
  output logic              hst_rvalid,
  output logic [DATA_W-1:0] hst_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic              ram_oe,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W:0]   hwm
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]       stat_ld,
  output logic [15:0]       stat_sgd,
  output logic [15:0]       stat_hst,
  output logic [15:0]       stat_stall
`endif
);

  localparam logic SRC_SGD = 1'b0;
  localparam logic SRC_HST = 1'b1;

  logic              r_rr_hst;
  logic [ADDR_W:0]   r_hwm;
  logic [ADDR_W-1:0] r_ram_addr;
  logic              r_ram_we;
  logic              r_ram_oe;
  logic [DATA_W-1:0] r_ram_wdata;
  logic [RD_LAT:0]   r_vld_pipe;
  logic [RD_LAT:0]   r_src_pipe;
  logic              r_sgd_rvalid;
  logic              r_hst_rvalid;
  logic [DATA_W-1:0] r_sgd_rdata;
  logic [DATA_W-1:0] r_hst_rdata;

  logic              w_sgd_elig;
  logic              w_hst_elig;
  logic              w_ld_gnt;
  logic              w_sgd_gnt;
  logic              w_hst_gnt;
  logic              w_rd_gnt;
  logic [ADDR_W-1:0] w_rd_addr;
  logic              w_hwm_bump;
  logic [ADDR_W:0]   w_hwm_next;
  logic              w_ret_vld;
  logic              w_ret_src;

  // r_rr_hst names the reader that wins the next tie; it flips to the loser on each read grant.
  always_comb begin
    w_sgd_elig = sgd_req && ({1'b0, sgd_addr} < r_hwm);
    w_hst_elig = hst_req;
    w_ld_gnt   = !RST && ld_req;
    w_sgd_gnt  = !RST && !ld_req && w_sgd_elig && (!w_hst_elig || !r_rr_hst);
    w_hst_gnt  = !RST && !ld_req && w_hst_elig && (!w_sgd_elig || r_rr_hst);
    w_rd_gnt   = w_sgd_gnt || w_hst_gnt;
    w_rd_addr  = w_hst_gnt ? hst_addr : sgd_addr;
    w_hwm_bump = w_ld_gnt && (ld_start || ({1'b0, ld_addr} >= r_hwm));
    w_hwm_next = {1'b0, ld_addr} + {{ADDR_W{1'b0}}, 1'b1};
    w_ret_vld  = r_vld_pipe[RD_LAT];
    w_ret_src  = r_src_pipe[RD_LAT];
  end

  assign ld_gnt  = w_ld_gnt;
  assign sgd_gnt = w_sgd_gnt;
  assign hst_gnt = w_hst_gnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rr_hst <= SRC_SGD;
      r_hwm    <= '0;
    end else begin
      if (w_rd_gnt) r_rr_hst <= w_sgd_gnt;
      // ld_addr+1 tops out at 2^ADDR_W, which is the saturation point of hwm
      if (w_hwm_bump)    r_hwm <= w_hwm_next;
      else if (ld_start) r_hwm <= '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ram_addr  <= '0;
      r_ram_we    <= 1'b0;
      r_ram_oe    <= 1'b0;
      r_ram_wdata <= '0;
    end else begin
      r_ram_we <= w_ld_gnt;
      r_ram_oe <= w_rd_gnt;
      if (w_ld_gnt) begin
        r_ram_addr  <= ld_addr;
        r_ram_wdata <= ld_wdata;
      end else if (w_rd_gnt) begin
        r_ram_addr  <= w_rd_addr;
      end
    end
  end

  // Stage 0 travels alongside ram_oe; stage RD_LAT lines up with the cycle ram_rdata is valid.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_vld_pipe <= '0;
      r_src_pipe <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[RD_LAT-1:0], w_rd_gnt};
      r_src_pipe <= {r_src_pipe[RD_LAT-1:0], w_hst_gnt};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sgd_rvalid <= 1'b0;
      r_hst_rvalid <= 1'b0;
      r_sgd_rdata  <= '0;
      r_hst_rdata  <= '0;
    end else begin
      r_sgd_rvalid <= w_ret_vld && (w_ret_src == SRC_SGD);
      r_hst_rvalid <= w_ret_vld && (w_ret_src == SRC_HST);
      if (w_ret_vld && (w_ret_src == SRC_SGD)) r_sgd_rdata <= ram_rdata;
      if (w_ret_vld && (w_ret_src == SRC_HST)) r_hst_rdata <= ram_rdata;
    end
  end

  assign ram_addr   = r_ram_addr;
  assign ram_we     = r_ram_we;
  assign ram_oe     = r_ram_oe;
  assign ram_wdata  = r_ram_wdata;
  assign sgd_rvalid = r_sgd_rvalid;
  assign sgd_rdata  = r_sgd_rdata;
  assign hst_rvalid = r_hst_rvalid;
  assign hst_rdata  = r_hst_rdata;
  assign hwm        = r_hwm;

`ifdef ARB_STATS_EN
  logic [15:0] r_stat_ld;
  logic [15:0] r_stat_sgd;
  logic [15:0] r_stat_hst;
  logic [15:0] r_stat_stall;

  // Counters survive ld_start so they span a whole session of datasets.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_stat_ld    <= '0;
      r_stat_sgd   <= '0;
      r_stat_hst   <= '0;
      r_stat_stall <= '0;
    end else begin
      if (w_ld_gnt && (r_stat_ld != 16'hFFFF))   r_stat_ld  <= r_stat_ld + 16'd1;
      if (w_sgd_gnt && (r_stat_sgd != 16'hFFFF)) r_stat_sgd <= r_stat_sgd + 16'd1;
      if (w_hst_gnt && (r_stat_hst != 16'hFFFF)) r_stat_hst <= r_stat_hst + 16'd1;
      if (sgd_req && !w_sgd_gnt && (r_stat_stall != 16'hFFFF))
        r_stat_stall <= r_stat_stall + 16'd1;
    end
  end

  assign stat_ld    = r_stat_ld;
  assign stat_sgd   = r_stat_sgd;
  assign stat_hst   = r_stat_hst;
  assign stat_stall = r_stat_stall;
`endif

endmodule

// File: tb/tb_sgd_mem_arbiter.sv
// Bench for sgd_mem_arbiter: two instances (RD_LAT 1 and 3) share directed stimulus and are
// checked every cycle against a transaction-level model plus hand-computed expectations.
module tb_sgd_mem_arbiter;
  localparam int AW = 12;
  localparam int DW = 192;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic          RST, ld_start, ld_req, sgd_req, hst_req;
  logic [AW-1:0] ld_addr, sgd_addr, hst_addr;
  logic [DW-1:0] ld_wdata;

  logic [1:0]         ld_gnt_o, sgd_gnt_o, hst_gnt_o, sgd_rv_o, hst_rv_o, we_o, oe_o;
  logic [1:0][DW-1:0] sgd_rd_o, hst_rd_o, wd_o, rdata_w;
  logic [1:0][AW-1:0] addr_o;
  logic [1:0][AW:0]   hwm_o;
`ifdef ARB_STATS_EN
  logic [1:0][15:0]   st_ld, st_sgd, st_hst, st_stall;
`endif

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [DW-1:0] dat(input int v);
    return {64'(v), ~64'(v), 64'(v)};
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_dut
    localparam int L = (k == 0) ? 1 : 3;
    logic [DW-1:0] mem [4096];
    logic [DW-1:0] rp [L];

    sgd_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(L)) u_dut (
      .CLK(CLK), .RST(RST), .ld_start(ld_start),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt_o[k]),
      .sgd_req(sgd_req), .sgd_addr(sgd_addr), .sgd_gnt(sgd_gnt_o[k]),
      .sgd_rvalid(sgd_rv_o[k]), .sgd_rdata(sgd_rd_o[k]),
      .hst_req(hst_req), .hst_addr(hst_addr), .hst_gnt(hst_gnt_o[k]),
      .hst_rvalid(hst_rv_o[k]), .hst_rdata(hst_rd_o[k]),
      .ram_addr(addr_o[k]), .ram_we(we_o[k]), .ram_oe(oe_o[k]), .ram_wdata(wd_o[k]),
      .ram_rdata(rdata_w[k]), .hwm(hwm_o[k])
`ifdef ARB_STATS_EN
      , .stat_ld(st_ld[k]), .stat_sgd(st_sgd[k]), .stat_hst(st_hst[k]), .stat_stall(st_stall[k])
`endif
    );

    // Synchronous RAM with L cycles from address to data.
    always @(posedge CLK) begin
      if (we_o[k]) mem[addr_o[k]] <= wd_o[k];
      rp[0] <= mem[addr_o[k]];
      for (int j = 1; j < L; j++) rp[j] <= rp[j-1];
    end
    assign rdata_w[k] = rp[L-1];
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- transaction-level model ----------------
  int            cyc = 0;
  bit            chk_en = 1'b0;
  bit            m_was_rst;
  int            m_hwm;
  bit            m_pref_hst;
  logic [AW-1:0] m_addr;
  bit            m_we, m_oe;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_mem [int];
  bit            ev [2][8];
  bit            es [2][8];
  logic [DW-1:0] ed [2][8];
  logic [DW-1:0] m_srd [2];
  logic [DW-1:0] m_hrd [2];

  function automatic void exp_gnt(output bit gl, output bit gs, output bit gh);
    bit se, he;
    gl = 1'b0; gs = 1'b0; gh = 1'b0;
    se = sgd_req && (int'(sgd_addr) < m_hwm);
    he = hst_req;
    if (RST) return;
    if (ld_req) gl = 1'b1;
    else if (se && he) begin
      gh = m_pref_hst;
      gs = !m_pref_hst;
    end else begin
      gs = se;
      gh = he;
    end
  endfunction

  always @(posedge CLK) begin
    bit gl, gs, gh;
    int slot;
    int ra;
    exp_gnt(gl, gs, gh);
    for (int i = 0; i < 2; i++) ev[i][cyc % 8] = 1'b0;
    cyc++;
    m_was_rst = RST;
    if (RST) begin
      chk_en = 1'b1;
      m_hwm = 0; m_pref_hst = 1'b0; m_addr = '0; m_we = 1'b0; m_oe = 1'b0; m_wdata = '0;
      for (int i = 0; i < 2; i++)
        for (int s = 0; s < 8; s++) ev[i][s] = 1'b0;
    end else begin
      m_we = gl;
      m_oe = gs || gh;
      if (gl) begin
        m_addr  = ld_addr;
        m_wdata = ld_wdata;
        m_mem[int'(ld_addr)] = ld_wdata;
        if (ld_start || int'(ld_addr) >= m_hwm) m_hwm = int'(ld_addr) + 1;
      end else if (ld_start) begin
        m_hwm = 0;
      end
      if (gs || gh) begin
        ra = gh ? int'(hst_addr) : int'(sgd_addr);
        m_addr = AW'(ra);
        m_pref_hst = gs;
        for (int i = 0; i < 2; i++) begin
          slot = (cyc + lat(i) + 1) % 8;
          ev[i][slot] = 1'b1;
          es[i][slot] = gh;
          ed[i][slot] = m_mem.exists(ra) ? m_mem[ra] : '0;
        end
      end
    end
  end

  always @(negedge CLK) begin
    bit gl, gs, gh;
    int s;
    if (chk_en) begin
      exp_gnt(gl, gs, gh);
      s = cyc % 8;
      for (int i = 0; i < 2; i++) begin
        if (m_was_rst) begin
          m_srd[i] = '0;
          m_hrd[i] = '0;
        end
        if (ev[i][s] && !es[i][s]) m_srd[i] = ed[i][s];
        if (ev[i][s] && es[i][s])  m_hrd[i] = ed[i][s];
        chk($sformatf("i%0d ld_gnt", i),     DW'(ld_gnt_o[i]),  DW'(gl));
        chk($sformatf("i%0d sgd_gnt", i),    DW'(sgd_gnt_o[i]), DW'(gs));
        chk($sformatf("i%0d hst_gnt", i),    DW'(hst_gnt_o[i]), DW'(gh));
        chk($sformatf("i%0d ram_we", i),     DW'(we_o[i]),      DW'(m_we));
        chk($sformatf("i%0d ram_oe", i),     DW'(oe_o[i]),      DW'(m_oe));
        chk($sformatf("i%0d ram_addr", i),   DW'(addr_o[i]),    DW'(m_addr));
        chk($sformatf("i%0d ram_wdata", i),  wd_o[i],           m_wdata);
        chk($sformatf("i%0d hwm", i),        DW'(hwm_o[i]),     DW'(m_hwm));
        chk($sformatf("i%0d sgd_rvalid", i), DW'(sgd_rv_o[i]),  DW'(ev[i][s] && !es[i][s]));
        chk($sformatf("i%0d hst_rvalid", i), DW'(hst_rv_o[i]),  DW'(ev[i][s] && es[i][s]));
        chk($sformatf("i%0d sgd_rdata", i),  sgd_rd_o[i],       m_srd[i]);
        chk($sformatf("i%0d hst_rdata", i),  hst_rd_o[i],       m_hrd[i]);
      end
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic at_neg();
    @(negedge CLK);
  endtask

  task automatic write_row(input int a, input int v, input bit start);
    ld_req = 1'b1; ld_addr = AW'(a); ld_wdata = dat(v); ld_start = start;
    at_neg();
    chk("write ld_gnt", DW'(ld_gnt_o), DW'(2'b11));
    step();
    ld_req = 1'b0; ld_start = 1'b0;
  endtask

  initial begin
    RST = 1'b1; ld_start = 1'b0; ld_req = 1'b0; sgd_req = 1'b0; hst_req = 1'b0;
    ld_addr = '0; sgd_addr = '0; hst_addr = '0; ld_wdata = '0;
    step(); step();
    at_neg();
    chk("reset hwm", DW'(hwm_o[0]), DW'(0));
    chk("reset we/oe", DW'({we_o, oe_o}), DW'(0));
    step();
    RST = 1'b0;

    // Load rows 0..3
    for (int i = 0; i < 4; i++) write_row(i, 'hA0 + i, 1'b0);
    at_neg();
    chk("load hwm", DW'(hwm_o[1]), DW'(4));
    chk("load last we", DW'(we_o), DW'(2'b11));
    chk("load last wdata", wd_o[0], dat('hA3));
    step();

    // RAW stall: hwm=2, SGD wants row 5
    ld_start = 1'b1;
    at_neg(); step();
    ld_start = 1'b0;
    write_row(0, 'hB0, 1'b0);
    write_row(1, 'hB1, 1'b0);
    sgd_req = 1'b1; sgd_addr = AW'(5);
    at_neg();
    chk("raw hwm", DW'(hwm_o[0]), DW'(2));
    chk("raw stall a", DW'(sgd_gnt_o), DW'(0));
    step();
    write_row(2, 'hB2, 1'b0);
    at_neg();
    chk("raw stall b", DW'(sgd_gnt_o), DW'(0));
    step();
    write_row(5, 'hC5, 1'b0);
    at_neg();
    chk("raw grant", DW'(sgd_gnt_o), DW'(2'b11));
    chk("raw hwm6", DW'(hwm_o[0]), DW'(6));
    step();
    sgd_req = 1'b0;
    for (int j = 0; j < 5; j++) begin
      at_neg();
      chk("raw rvalid", DW'(sgd_rv_o), DW'({j == 4, j == 2}));
      if (j == 2) chk("raw rdata l1", sgd_rd_o[0], dat('hC5));
      if (j == 4) chk("raw rdata l3", sgd_rd_o[1], dat('hC5));
      step();
    end

    // Contention straight out of reset
    RST = 1'b1;
    step();
    RST = 1'b0;
    ld_req = 1'b1; ld_addr = AW'(0); ld_wdata = dat('hD0);
    sgd_req = 1'b1; sgd_addr = AW'(0);
    hst_req = 1'b1; hst_addr = AW'(1);
    at_neg();
    chk("cont c1", DW'({ld_gnt_o[0], sgd_gnt_o[0], hst_gnt_o[0]}), DW'(3'b100));
    step();
    ld_req = 1'b0;
    at_neg();
    chk("cont c2", DW'({ld_gnt_o[0], sgd_gnt_o[0], hst_gnt_o[0]}), DW'(3'b010));
    step();
    sgd_req = 1'b0;
    at_neg();
    chk("cont c3", DW'({ld_gnt_o[0], sgd_gnt_o[0], hst_gnt_o[0]}), DW'(3'b001));
    step();
    hst_req = 1'b0;
    for (int j = 0; j < 5; j++) begin
      at_neg();
      chk("cont rv l1", DW'({sgd_rv_o[0], hst_rv_o[0]}), DW'({j == 1, j == 2}));
      chk("cont rv l3", DW'({sgd_rv_o[1], hst_rv_o[1]}), DW'({j == 3, j == 4}));
      step();
    end
    chk("cont sgd data", sgd_rd_o[1], dat('hD0));
    chk("cont hst data", hst_rd_o[1], dat('hB1));

    // Streaming host reads of rows 0..7
    for (int i = 0; i < 8; i++) write_row(i, 'hE0 + i, i == 0);
    for (int j = 0; j < 15; j++) begin
      hst_req = (j < 8); hst_addr = AW'(j < 8 ? j : 0);
      at_neg();
      if (j < 8) chk("stream gnt", DW'(hst_gnt_o), DW'(2'b11));
      chk("stream rv l1", DW'(hst_rv_o[0]), DW'(j >= 3 && j <= 10));
      chk("stream rv l3", DW'(hst_rv_o[1]), DW'(j >= 5 && j <= 12));
      if (j >= 3 && j <= 10) chk("stream data l1", hst_rd_o[0], dat('hE0 + j - 3));
      if (j >= 5 && j <= 12) chk("stream data l3", hst_rd_o[1], dat('hE0 + j - 5));
      step();
    end
    hst_req = 1'b0;

    // Reset the cycle after an SGD grant
    sgd_req = 1'b1; sgd_addr = AW'(2);
    at_neg();
    chk("rst rd gnt", DW'(sgd_gnt_o), DW'(2'b11));
    step();
    sgd_req = 1'b0; RST = 1'b1;
    at_neg(); step();
    RST = 1'b0;
    at_neg();
    chk("rst hwm", DW'(hwm_o), DW'(0));
    chk("rst ram", DW'({we_o, oe_o, addr_o}), DW'(0));
    chk("rst rdata", sgd_rd_o[0] | sgd_rd_o[1] | hst_rd_o[0] | hst_rd_o[1], DW'(0));
    for (int j = 0; j < 5; j++) begin
      step(); at_neg();
      chk("rst no rvalid", DW'(sgd_rv_o), DW'(0));
    end
    step();

    // ld_start together with a write of row 9
    for (int i = 0; i < 4; i++) write_row(i, 'hF0 + i, 1'b0);
    write_row(9, 'hF9, 1'b1);
    sgd_req = 1'b1; sgd_addr = AW'(3);
    at_neg();
    chk("start hwm", DW'(hwm_o[0]), DW'(10));
    chk("start sgd gnt", DW'(sgd_gnt_o), DW'(2'b11));
    step();
    sgd_addr = AW'(10);
    at_neg();
    chk("hwm edge stall", DW'(sgd_gnt_o), DW'(0));
    step();
    sgd_addr = AW'(9);
    at_neg();
    chk("hwm edge gnt", DW'(sgd_gnt_o), DW'(2'b11));
    step();
    sgd_req = 1'b0;
    write_row(4095, 'hFF, 1'b0);
    at_neg();
    chk("hwm top", DW'(hwm_o[1]), DW'(4096));
    repeat (6) step();
    chk("start rd data", sgd_rd_o[1], dat('hF9));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
